rms_ctx_stack: RTL and testbench

//  Parametrised register management block: NREGS x WIDTH register file (2 read, 2 write ports)

---
 rtl/rms_ctx_stack_if.sv | 34 +++
 rtl/rms_ctx_stack.sv | 185 ++++++++++++++++++
 tb/tb_rms_ctx_stack.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rms_ctx_stack_if.sv
// Request/response bundle for rms_ctx_stack: register-file ports, frame-stack handshake,
// and compare unit.
interface rms_ctx_stack_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 64,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned SW = $clog2(DEPTH + 1);

    logic [AW-1:0]    a1, a2;
    logic [WIDTH-1:0] r1, r2;
    logic             w1_en, w2_en;
    logic [AW-1:0]    w1_addr, w2_addr;
    logic [WIDTH-1:0] w1_data, w2_data;
    logic             save, restore;
    logic             busy, done;
    logic [SW-1:0]    sp;
    logic             ovf, unf;
    logic [1:0]       cmp_mode;
    logic             cmp_result;

    modport master (
        output a1, a2, w1_en, w1_addr, w1_data, w2_en, w2_addr, w2_data, save, restore,
               cmp_mode,
        input  r1, r2, busy, done, sp, ovf, unf, cmp_result
    );

    modport slave (
        input  a1, a2, w1_en, w1_addr, w1_data, w2_en, w2_addr, w2_data, save, restore,
               cmp_mode,
        output r1, r2, busy, done, sp, ovf, unf, cmp_result
    );
endinterface

// File: rtl/rms_ctx_stack.sv
// 2R/2W register file with a DEPTH-frame call stack that saves/restores a register window,
// plus a compare unit. Define RMS_FAST_CTX_EN for single-edge whole-window push/pop.
module rms_ctx_stack #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NREGS     = 64,
    parameter int unsigned SAVE_BASE = 1,
    parameter int unsigned NSAVE     = 15,
    parameter int unsigned DEPTH     = 8
) (
    input logic            clk,
    input logic            reset,
    rms_ctx_stack_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned SW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StPush, StPop} state_e;
    state_e state_q, state_d;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [SW-1:0]    sp_q;
    logic             done_q, ovf_q, unf_q;
    logic             req_save, req_restore, idle, push_go, pop_go;
    logic             busy, xfer_end, sp_inc, sp_dec;

    // Simultaneous save+restore cancel each other out.
    assign req_save    = bus.save & ~bus.restore;
    assign req_restore = bus.restore & ~bus.save;
    assign idle        = (state_q == StIdle);
    assign push_go     = idle && req_save && (sp_q != SW'(DEPTH));
    assign pop_go      = idle && req_restore && (sp_q != '0);

`ifndef RMS_FAST_CTX_EN
    localparam int unsigned KW = (NSAVE > 1) ? $clog2(NSAVE) : 1;
    localparam int unsigned MD = DEPTH * NSAVE;
    localparam int unsigned MW = (MD > 1) ? $clog2(MD) : 1;

    logic [WIDTH-1:0] stack_q [MD];
    logic [KW-1:0]    k_q;
    logic             last;
    logic [AW-1:0]    win_idx;
    logic [SW-1:0]    frame;
    logic [MW-1:0]    mem_idx;

    // Frames are laid out flat so a single WIDTH-wide port serves both push and pop.
    assign last    = (k_q == KW'(NSAVE - 1));
    assign win_idx = AW'(SAVE_BASE + 32'(k_q));
    assign frame   = (state_q == StPop) ? sp_q - SW'(1) : sp_q;
    assign mem_idx = MW'(32'(frame) * NSAVE + 32'(k_q));

    always_ff @(posedge clk) begin
        if (state_q == StPush) stack_q[mem_idx] <= regs_q[win_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= (idle || last) ? '0 : k_q + KW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (push_go)     state_d = StPush;
                else if (pop_go) state_d = StPop;
            end
            StPush, StPop: if (last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        sp_inc = 1'b0;
        sp_dec = 1'b0;
        unique case (state_q)
            StPush: begin
                busy   = 1'b1;
                sp_inc = last;
            end
            StPop: begin
                busy   = 1'b1;
                sp_dec = last;
            end
            default: ;
        endcase
        xfer_end = sp_inc | sp_dec;
    end
`else
    localparam int unsigned FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NSAVE*WIDTH-1:0] stack_q [DEPTH];
    logic [NSAVE*WIDTH-1:0] window;
    logic [FW-1:0]          push_row, pop_row;

    assign push_row = FW'(sp_q);
    assign pop_row  = FW'(sp_q - SW'(1));

    always_comb begin
        window = '0;
        for (int j = 0; j < int'(NSAVE); j++) begin
            window[j*WIDTH +: WIDTH] = regs_q[AW'(SAVE_BASE + 32'(j))];
        end
    end

    always_ff @(posedge clk) begin
        if (push_go) stack_q[push_row] <= window;
    end

    // The whole window moves on one edge, so the FSM never leaves idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = StIdle;
    end

    always_comb begin
        busy     = 1'b0;
        sp_inc   = push_go;
        sp_dec   = pop_go;
        xfer_end = push_go | pop_go;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            if (!busy) begin
                if (bus.w1_en) regs_q[bus.w1_addr] <= bus.w1_data;
                if (bus.w2_en) regs_q[bus.w2_addr] <= bus.w2_data;
            end
`ifndef RMS_FAST_CTX_EN
            if (state_q == StPop) regs_q[win_idx] <= stack_q[mem_idx];
`else
            // Pop data lands after port writes so it wins for window addresses.
            if (pop_go) begin
                for (int j = 0; j < int'(NSAVE); j++) begin
                    regs_q[AW'(SAVE_BASE + 32'(j))] <= stack_q[pop_row][j*WIDTH +: WIDTH];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q   <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            done_q <= xfer_end;
            if (sp_inc)      sp_q <= sp_q + SW'(1);
            else if (sp_dec) sp_q <= sp_q - SW'(1);
            if (idle && req_save && (sp_q == SW'(DEPTH))) ovf_q <= 1'b1;
            if (idle && req_restore && (sp_q == '0))      unf_q <= 1'b1;
        end
    end

    assign bus.r1   = regs_q[bus.a1];
    assign bus.r2   = regs_q[bus.a2];
    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.sp   = sp_q;
    assign bus.ovf  = ovf_q;
    assign bus.unf  = unf_q;

    always_comb begin
        case (bus.cmp_mode)
            2'b01:   bus.cmp_result = (bus.r1 == bus.r2);
            2'b10:   bus.cmp_result = (bus.r1 != bus.r2);
            2'b11:   bus.cmp_result = ($signed(bus.r1) < $signed(bus.r2));
            default: bus.cmp_result = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_rms_ctx_stack.sv
// Directed self-checking bench for rms_ctx_stack (serial build by default, RMS_FAST_CTX_EN
// selects the single-edge expectations).
module tb_rms_ctx_stack;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREGS = 64;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NSAVE = 15;
`ifdef RMS_FAST_CTX_EN
    localparam int BUSY_CYC = 0;
`else
    localparam int BUSY_CYC = 15;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    logic [31:0] rd;

    rms_ctx_stack_if #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) bus ();

    rms_ctx_stack #(
        .WIDTH(WIDTH), .NREGS(NREGS), .SAVE_BASE(1), .NSAVE(NSAVE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a1 = '0; bus.a2 = '0;
        bus.w1_en = 1'b0; bus.w1_addr = '0; bus.w1_data = '0;
        bus.w2_en = 1'b0; bus.w2_addr = '0; bus.w2_data = '0;
        bus.save = 1'b0; bus.restore = 1'b0; bus.cmp_mode = 2'b00;
    endtask

    task automatic write_reg(input int addr, input logic [15:0] data);
        bus.w1_en = 1'b1; bus.w1_addr = 6'(addr); bus.w1_data = data;
        tick();
        bus.w1_en = 1'b0;
    endtask

    task automatic read_reg(input int addr, output logic [31:0] data);
        bus.a1 = 6'(addr);
        #1;
        data = 32'(bus.r1);
    endtask

    // Pulse save/restore, then count busy cycles until done (bounded).
    task automatic xfer(input bit is_save, input bit inject, input string tag);
        int n = 0;
        int nbusy = 0;
        bus.save = is_save; bus.restore = !is_save;
        tick();
        bus.save = 1'b0; bus.restore = 1'b0;
        while (!bus.done && n < 40) begin
            if (bus.busy) nbusy++;
            if (inject && n == 0 && bus.busy) begin
                bus.w1_en = 1'b1; bus.w1_addr = 6'd3; bus.w1_data = 16'hAAAA;
            end
            if (inject && n == 3) check("reg20 during busy", 32'(bus.r2), 32'h5A5A);
            tick();
            bus.w1_en = 1'b0;
            n++;
        end
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " busy cycles"}, nbusy, BUSY_CYC);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;

        bus.a1 = 6'd5; bus.a2 = 6'd63;
        #1;
        check("reset r1", 32'(bus.r1), 32'h0);
        check("reset r2", 32'(bus.r2), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);
        check("reset done", 32'(bus.done), 32'h0);
        check("reset sp", 32'(bus.sp), 32'h0);
        check("reset ovf", 32'(bus.ovf), 32'h0);
        check("reset unf", 32'(bus.unf), 32'h0);

        // Same-address dual write: port 2 wins.
        bus.w1_en = 1'b1; bus.w1_addr = 6'd5; bus.w1_data = 16'h1234;
        bus.w2_en = 1'b1; bus.w2_addr = 6'd5; bus.w2_data = 16'hBEEF;
        #1;
        check("no bypass", 32'(bus.r1), 32'h0);
        tick();
        bus.w1_en = 1'b0; bus.w2_en = 1'b0;
        #1;
        check("w2 wins", 32'(bus.r1), 32'hBEEF);

        // Compare unit.
        bus.w1_en = 1'b1; bus.w1_addr = 6'd30; bus.w1_data = 16'hFFFF;
        bus.w2_en = 1'b1; bus.w2_addr = 6'd31; bus.w2_data = 16'h0001;
        tick();
        bus.w1_en = 1'b0; bus.w2_en = 1'b0;
        bus.a1 = 6'd30; bus.a2 = 6'd31;
        bus.cmp_mode = 2'b11; #1; check("cmp lt -1<1", 32'(bus.cmp_result), 32'd1);
        bus.cmp_mode = 2'b01; #1; check("cmp eq", 32'(bus.cmp_result), 32'd0);
        bus.cmp_mode = 2'b10; #1; check("cmp ne", 32'(bus.cmp_result), 32'd1);
        bus.cmp_mode = 2'b00; #1; check("cmp none", 32'(bus.cmp_result), 32'd0);
        bus.a1 = 6'd31; bus.a2 = 6'd30;
        bus.cmp_mode = 2'b11; #1; check("cmp lt 1<-1", 32'(bus.cmp_result), 32'd0);
        bus.a2 = 6'd31;
        bus.cmp_mode = 2'b01; #1; check("cmp eq same", 32'(bus.cmp_result), 32'd1);
        bus.cmp_mode = 2'b00;

        // Save/restore round trip; write during busy is dropped.
        for (int i = 1; i <= 15; i++) write_reg(i, 16'(16'h0100 + i));
        write_reg(20, 16'h5A5A);
        write_reg(0, 16'h00C0);
        bus.a2 = 6'd20;
        xfer(1'b1, 1'b1, "save");
        check("sp after save", 32'(bus.sp), 32'd1);
        tick();
        check("done one cycle", 32'(bus.done), 32'd0);
        read_reg(3, rd);
        check("reg3 write dropped", rd, 32'h0103);
        for (int i = 1; i <= 15; i++) write_reg(i, 16'h0);
        read_reg(7, rd);
        check("reg7 cleared", rd, 32'h0);
        xfer(1'b0, 1'b0, "restore");
        check("sp after restore", 32'(bus.sp), 32'd0);
        for (int i = 1; i <= 15; i++) begin
            read_reg(i, rd);
            check($sformatf("restored reg%0d", i), rd, 32'(16'h0100 + i));
        end
        read_reg(0, rd);
        check("reg0 untouched", rd, 32'h00C0);
        read_reg(20, rd);
        check("reg20 untouched", rd, 32'h5A5A);

        // Fill the stack, then overflow.
        for (int f = 0; f < 8; f++) xfer(1'b1, 1'b0, "fill");
        check("sp full", 32'(bus.sp), 32'd8);
        bus.save = 1'b1;
        tick();
        bus.save = 1'b0;
        check("ovf set", 32'(bus.ovf), 32'd1);
        check("ovf no busy", 32'(bus.busy), 32'd0);
        check("ovf no done", 32'(bus.done), 32'd0);
        tick();
        check("ovf no done later", 32'(bus.done), 32'd0);
        check("ovf sp held", 32'(bus.sp), 32'd8);
        check("ovf no unf", 32'(bus.unf), 32'd0);

        // Fresh run: simultaneous request is a no-op, then underflow.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ovf cleared by reset", 32'(bus.ovf), 32'd0);
        bus.save = 1'b1; bus.restore = 1'b1;
        tick();
        bus.save = 1'b0; bus.restore = 1'b0;
        check("both no busy", 32'(bus.busy), 32'd0);
        check("both no done", 32'(bus.done), 32'd0);
        check("both no unf", 32'(bus.unf), 32'd0);
        check("both no ovf", 32'(bus.ovf), 32'd0);
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        check("unf set", 32'(bus.unf), 32'd1);
        check("unf no busy", 32'(bus.busy), 32'd0);
        check("unf no done", 32'(bus.done), 32'd0);
        check("unf sp", 32'(bus.sp), 32'd0);

`ifndef RMS_FAST_CTX_EN
        // Reset mid-push at k=7.
        write_reg(5, 16'h0077);
        bus.save = 1'b1;
        tick();
        bus.save = 1'b0;
        repeat (7) tick();
        check("mid push busy", 32'(bus.busy), 32'd1);
        bus.a1 = 6'd5;
        #2 reset = 1'b1;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort sp", 32'(bus.sp), 32'd0);
        check("abort reg5", 32'(bus.r1), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("abort sp later", 32'(bus.sp), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
